peripheral_bus_splitter: RTL

Upstream front end for the example peripheral: accepts one 32-bit Avalon-MM slave port from the system interconnect and splits it into the peripheral's separate register port and memory port. It registers and forwards commands, tracks outstanding reads in order with a small tag FIFO, and merges the two read-response streams back into one in-order response stream. It also answers out-of-range register reads locally and raises a sticky error flag.

---
 rtl/peripheral_bus_splitter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/peripheral_bus_splitter.sv
// Splits one Avalon-MM slave port into register and memory ports, merging read responses in order.
// Optional PERIPHERAL_SPLITTER_TIMEOUT_EN: answers a stuck read with 0xDEAD_0000 after TIMEOUT cycles.
module peripheral_bus_splitter #(
    parameter int REGS        = 5,
    parameter int MAX_PENDING = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [8:0]  avs_address,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic        avs_readdatavalid,
    output logic [31:0] avs_readdata,
    output logic        reg_read,
    output logic        reg_write,
    output logic [2:0]  reg_address,
    output logic [31:0] reg_data_in,
    input  logic        reg_read_valid,
    input  logic [31:0] reg_data_out,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_address,
    output logic [31:0] mem_data_in,
    input  logic        mem_read_valid,
    input  logic [31:0] mem_data_out,
    output logic        err,
    input  logic        err_clear
);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] IDX_LIMIT = 4'(REGS);

    typedef enum logic [1:0] {
        TAG_REG   = 2'd0,
        TAG_MEM   = 2'd1,
        TAG_LOCAL = 2'd2
    } tag_t;

    tag_t             tag_mem [MAX_PENDING];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic        accept, wr_cmd, rd_cmd, is_mem, bad_index, to_reg;
    logic        fifo_empty, pop_reg, pop_mem, pop_local, pop_timeout, pop;
    logic        err_set;
    tag_t        head_tag, push_tag;
    logic [31:0] resp_data;

    assign avs_waitrequest = (count_reg == CNT_W'(MAX_PENDING));

    always_comb begin
        accept    = (avs_read | avs_write) & ~avs_waitrequest;
        wr_cmd    = accept & avs_write;
        // A simultaneous read strobe is discarded in favour of the write.
        rd_cmd    = accept & avs_read & ~avs_write;
        is_mem    = avs_address[8];
        bad_index = ~is_mem & ({1'b0, avs_address[2:0]} >= IDX_LIMIT);
        to_reg    = ~is_mem & ~bad_index;
        push_tag  = is_mem ? TAG_MEM : (bad_index ? TAG_LOCAL : TAG_REG);

        fifo_empty = (count_reg == '0);
        head_tag   = tag_mem[rd_ptr_reg];
        pop_reg    = ~fifo_empty & (head_tag == TAG_REG) & reg_read_valid;
        pop_mem    = ~fifo_empty & (head_tag == TAG_MEM) & mem_read_valid;
        pop_local  = ~fifo_empty & (head_tag == TAG_LOCAL);
        pop        = pop_reg | pop_mem | pop_local | pop_timeout;

        resp_data = 32'h0000_0000;
        if (pop_reg)
            resp_data = reg_data_out;
        else if (pop_mem)
            resp_data = mem_data_out;
        else if (pop_timeout)
            resp_data = 32'hDEAD_0000;

        // Any response not consumed by the head tag is a stray and is dropped.
        err_set = (accept & avs_read & avs_write)
                | ((wr_cmd | rd_cmd) & bad_index)
                | (reg_read_valid & ~pop_reg)
                | (mem_read_valid & ~pop_mem)
                | pop_timeout;
    end

`ifdef PERIPHERAL_SPLITTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_reg;
    logic             head_waiting;

    assign head_waiting = ~fifo_empty & ((head_tag == TAG_REG) | (head_tag == TAG_MEM))
                        & ~pop_reg & ~pop_mem;
    assign pop_timeout  = head_waiting & (timer_reg == TMR_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset || !head_waiting || pop_timeout)
            timer_reg <= '0;
        else
            timer_reg <= timer_reg + TMR_W'(1);
    end
`else
    // TIMEOUT only matters in the timeout build; this is constant 0.
    assign pop_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rd_cmd)
            tag_mem[wr_ptr_reg] <= push_tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            reg_read          <= 1'b0;
            reg_write         <= 1'b0;
            reg_address       <= '0;
            reg_data_in       <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_address       <= '0;
            mem_data_in       <= '0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            err               <= 1'b0;
        end else begin
            reg_read  <= rd_cmd & to_reg;
            reg_write <= wr_cmd & to_reg;
            mem_read  <= rd_cmd & is_mem;
            mem_write <= wr_cmd & is_mem;
            if ((rd_cmd | wr_cmd) & to_reg) begin
                reg_address <= avs_address[2:0];
                reg_data_in <= avs_writedata;
            end
            if ((rd_cmd | wr_cmd) & is_mem) begin
                mem_address <= avs_address[7:0];
                mem_data_in <= avs_writedata;
            end

            if (rd_cmd)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(rd_cmd) - CNT_W'(pop);

            avs_readdatavalid <= pop;
            avs_readdata      <= resp_data;
            // A new error outranks a clear in the same cycle.
            err <= err_set | (err & ~err_clear);
        end
    end
endmodule
